// File: rtl/pctrl_pkg.sv
// pctrl_pkg: shared definitions for the serial packet controller.
//   ADDR_W, OP_W, DATA_W : default field widths of a frame
//   FRAME_LEN            : total frame length in bits (start + fields)
//   state_t              : receiver FSM state encoding
//   max3                 : helper used to size the field bit counter
package pctrl_pkg;

  localparam int ADDR_W    = 8;
  localparam int OP_W      = 3;
  localparam int DATA_W    = 62;
  localparam int FRAME_LEN = 1 + ADDR_W + OP_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_OP   = 2'd2,
    S_DATA = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pctrl_shift.sv
// pctrl_shift: serial-in shift register, MSB arrives first.
//   clk   : clock
//   nRst  : asynchronous active-low reset, clears the register
//   en    : shift enable
//   din   : serial data in
//   q     : parallel contents, first bit received ends up in q[W-1]
module pctrl_shift
  import pctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  // Truncating {q, din} drops the oldest bit; also valid for W == 1.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      q <= '0;
    end else if (en) begin
      q <= W'({q, din});
    end
  end

endmodule

// File: rtl/pctrl.sv
// pctrl: serial frame receiver that latches the opcode of frames addressed
// to this node.
//   clk     : clock, rx sampled on the rising edge
//   nRst    : asynchronous active-low reset
//   address : this node's address, compared when the last payload bit lands
//   rx      : serial line, idle high, one bit per clock
//   opcode  : last opcode accepted for this node
//
// Frame: start(0) | address MSB first | opcode MSB first | payload MSB first
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | waiting for a start bit (rx == 0)
// ADDR   | shifting in ADDR_W address bits
// OP     | shifting in OP_W opcode bits
// DATA   | shifting in DATA_W payload bits, compare on last
module pctrl #(
  parameter int ADDR_W = pctrl_pkg::ADDR_W,
  parameter int OP_W   = pctrl_pkg::OP_W,
  parameter int DATA_W = pctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rx,
  output logic [OP_W-1:0]   opcode
);

  import pctrl_pkg::*;

  localparam int FMAX  = max3(ADDR_W, OP_W, DATA_W);
  localparam int CNT_W = (FMAX > 1) ? $clog2(FMAX) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               en_addr, en_op, en_data, op_load;
  logic [ADDR_W-1:0]  addr_q;
  logic [OP_W-1:0]    op_q;
  // Payload is captured but has no consumer on this block.
  logic [DATA_W-1:0]  payload_unused;

  pctrl_shift #(.W(ADDR_W)) u_addr (
    .clk(clk), .nRst(nRst), .en(en_addr), .din(rx), .q(addr_q)
  );

  pctrl_shift #(.W(OP_W)) u_op (
    .clk(clk), .nRst(nRst), .en(en_op), .din(rx), .q(op_q)
  );

  pctrl_shift #(.W(DATA_W)) u_data (
    .clk(clk), .nRst(nRst), .en(en_data), .din(rx), .q(payload_unused)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opcode <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (op_load) begin
        opcode <= op_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en_addr   = 1'b0;
    en_op     = 1'b0;
    en_data   = 1'b0;
    op_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx) begin
          state_nxt = S_ADDR;
          cnt_nxt   = '0;
        end
      end
      S_ADDR: begin
        en_addr = 1'b1;
        if (cnt == CNT_W'(ADDR_W - 1)) begin
          state_nxt = S_OP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_OP: begin
        en_op = 1'b1;
        if (cnt == CNT_W'(OP_W - 1)) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        en_data = 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) begin
          // Address and opcode registers are complete here; the final
          // payload bit shifts in on this same edge.
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          op_load   = (addr_q == address);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pctrl.sv
// tb_pctrl: self-checking bench for pctrl with a bit-stream reference model.
module tb_pctrl;

  localparam int AW = 8;
  localparam int OW = 3;
  localparam int DW = 62;
  localparam int FL = 1 + AW + OW + DW;

  logic          clk;
  logic          nRst;
  logic          rx;
  logic [AW-1:0] address;
  logic [OW-1:0] opcode;

  int checks;
  int errors;

  // Reference model: collect bits from the first 0 seen on an idle line,
  // decode once a full frame's worth has arrived.
  bit            mq[$];
  logic [OW-1:0] exp_op;

  pctrl dut (
    .clk    (clk),
    .nRst   (nRst),
    .address(address),
    .rx     (rx),
    .opcode (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FL-1:0] mk_frame(input logic [AW-1:0] a,
                                             input logic [OW-1:0] o,
                                             input logic [DW-1:0] d);
    return {1'b0, a, o, d};
  endfunction

  task automatic model_step(input bit b);
    int a;
    int o;
    if (mq.size() == 0 && b == 1'b1) return;
    mq.push_back(b);
    if (mq.size() == FL) begin
      a = 0;
      o = 0;
      for (int k = 1; k <= AW; k++) a = a * 2 + int'(mq[k]);
      for (int k = AW + 1; k <= AW + OW; k++) o = o * 2 + int'(mq[k]);
      if (a == int'(address)) exp_op = OW'(o);
      mq.delete();
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_op = '0;
  endtask

  // Drive one bit, let the DUT sample it, then advance the model.
  task automatic drive_bit(input logic b);
    rx = b;
    @(posedge clk);
    #1;
    model_step(b);
  endtask

  task automatic test_reset();
    nRst    = 1'b0;
    rx      = 1'b1;
    address = 8'hAA;
    model_reset();
    #12;
    checks++;
    if (opcode !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: opcode=%0d expected=0", opcode);
    end
    @(negedge clk);
    nRst = 1'b1;
    drive_bit(1'b1);
    checks++;
    if (opcode !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: opcode=%0d expected=0", opcode);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 500; i++) begin
      drive_bit(1'b1);
      checks++;
      if (opcode !== 3'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: opcode=%0d expected=0", i, opcode);
      end
    end
  endtask

  task automatic test_basic();
    logic [FL-1:0] f;
    f = mk_frame(8'hAA, 3'd4, 62'd100);
    for (int i = FL - 1; i >= 0; i--) begin
      drive_bit(f[i]);
      checks++;
      if (opcode !== exp_op || opcode !== ((i == 0) ? 3'd4 : 3'd0)) begin
        errors++;
        $display("FAIL basic_edge%0d: opcode=%0d expected=%0d", FL - i, opcode,
                 (i == 0) ? 4 : 0);
      end
    end
    for (int i = 0; i < 10; i++) drive_bit(1'b1);
    checks++;
    if (opcode !== 3'd4) begin
      errors++;
      $display("FAIL basic_hold: opcode=%0d expected=4", opcode);
    end
  endtask

  task automatic test_mismatch();
    logic [FL-1:0] f;
    f = mk_frame(8'h55, 3'd6, 62'h1234_5678);
    for (int i = FL - 1; i >= 0; i--) drive_bit(f[i]);
    checks++;
    if (opcode !== 3'd4) begin
      errors++;
      $display("FAIL mismatch_55: opcode=%0d expected=4", opcode);
    end
    f = mk_frame(8'hAB, 3'd3, 62'h3FFF_0000_0000_FFFF);
    for (int i = FL - 1; i >= 0; i--) drive_bit(f[i]);
    checks++;
    if (opcode !== 3'd4 || opcode !== exp_op) begin
      errors++;
      $display("FAIL mismatch_ab: opcode=%0d expected=4", opcode);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*FL-1:0] f2;
    f2 = {mk_frame(8'hAA, 3'd2, 62'd7), mk_frame(8'hAA, 3'd7, 62'h2AAA_AAAA)};
    for (int i = 2 * FL - 1; i >= 0; i--) begin
      drive_bit(f2[i]);
      checks++;
      if (opcode !== exp_op) begin
        errors++;
        $display("FAIL b2b_edge%0d: opcode=%0d expected=%0d", 2 * FL - i, opcode, exp_op);
      end
      if (i == FL) begin
        checks++;
        if (opcode !== 3'd2) begin
          errors++;
          $display("FAIL b2b_first: opcode=%0d expected=2", opcode);
        end
      end
    end
    checks++;
    if (opcode !== 3'd7) begin
      errors++;
      $display("FAIL b2b_second: opcode=%0d expected=7", opcode);
    end
  endtask

  task automatic test_reset_midframe();
    logic [FL-1:0] f;
    f = mk_frame(8'hAA, 3'd5, '1);
    for (int i = FL - 1; i >= FL - 40; i--) drive_bit(f[i]);
    #1 nRst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (opcode !== 3'd0) begin
      errors++;
      $display("FAIL midreset_clear: opcode=%0d expected=0", opcode);
    end
    #1 nRst = 1'b1;
    for (int i = FL - 41; i >= 0; i--) begin
      drive_bit(f[i]);
      checks++;
      if (opcode !== exp_op || opcode !== 3'd0) begin
        errors++;
        $display("FAIL midreset_tail%0d: opcode=%0d expected=0", i, opcode);
      end
    end
    f = mk_frame(8'hAA, 3'd5, 62'h155);
    for (int i = FL - 1; i >= 0; i--) drive_bit(f[i]);
    checks++;
    if (opcode !== 3'd5 || opcode !== exp_op) begin
      errors++;
      $display("FAIL midreset_next: opcode=%0d expected=5", opcode);
    end
  endtask

  task automatic test_addr_change();
    logic [FL-1:0] f;
    address = 8'h11;
    f = mk_frame(8'h3C, 3'd1, 62'h0F0F);
    for (int i = FL - 1; i >= 0; i--) begin
      if (i == 0) address = 8'h3C;
      drive_bit(f[i]);
    end
    checks++;
    if (opcode !== 3'd1 || opcode !== exp_op) begin
      errors++;
      $display("FAIL addrchg_match: opcode=%0d expected=1", opcode);
    end
    f = mk_frame(8'h3C, 3'd6, 62'h0F0F);
    for (int i = FL - 1; i >= 0; i--) begin
      if (i == 0) address = 8'h3D;
      drive_bit(f[i]);
    end
    checks++;
    if (opcode !== 3'd1 || opcode !== exp_op) begin
      errors++;
      $display("FAIL addrchg_miss: opcode=%0d expected=1", opcode);
    end
    address = 8'hAA;
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
  endtask

  task automatic test_random();
    logic [FL-1:0] f;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int gap;
    for (int n = 0; n < 24; n++) begin
      a = ($urandom_range(0, 1) == 1) ? address : AW'($urandom);
      if ($urandom_range(0, 3) == 0) a = address ^ AW'(1 << $urandom_range(0, AW - 1));
      d = DW'({$urandom, $urandom});
      f = mk_frame(a, OW'($urandom), d);
      for (int i = FL - 1; i >= 0; i--) begin
        drive_bit(f[i]);
        checks++;
        if (opcode !== exp_op) begin
          errors++;
          $display("FAIL rand_f%0d_b%0d: opcode=%0d expected=%0d", n, i, opcode, exp_op);
        end
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRst   = 1'b0;
    rx     = 1'b1;
    address = 8'hAA;
    exp_op = '0;
    test_reset();
    test_idle();
    test_basic();
    test_mismatch();
    test_back_to_back();
    test_reset_midframe();
    test_addr_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pctrl.md
PCTRL -- requirements
Module: pctrl

Interface
REQ-001 Parameter ADDR_W, default 8, width of node address field and address input.
REQ-002 Parameter OP_W, default 3, width of opcode field and opcode output.
REQ-003 Parameter DATA_W, default 62, width of payload field.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 nRst  input  1  reset, asynchronous, active-low.
REQ-006 address  input  ADDR_W  this node's address, static during operation, compared at frame end.
REQ-007 rx  input  1  serial line, idle high, one bit per clk cycle, sampled on rising edge.
REQ-008 opcode  output  OP_W  last opcode accepted for this node, registered.

Function
REQ-009 Frame format SHALL be: start bit (0), ADDR_W address bits MSB first, OP_W opcode bits MSB first, DATA_W payload bits MSB first; 74 bits total at defaults, no stop bit.
REQ-010 FSM states SHALL be IDLE, ADDR, OP, DATA; a bit counter tracks position within the current field.
REQ-011 IDLE: rx=1 sampled -> stay IDLE; rx=0 sampled -> ADDR with counter cleared.
REQ-012 ADDR: shift rx into address shift register each cycle; after ADDR_W bits -> OP.
REQ-013 OP: shift rx into opcode shift register; after OP_W bits -> DATA.
REQ-014 DATA: shift rx into payload register; after DATA_W bits -> IDLE.
REQ-015 On the edge sampling the final payload bit, if captured address == address input, opcode SHALL load the captured opcode on that same edge; otherwise opcode is unchanged.
REQ-016 Latency: opcode updates exactly 74 cycles (defaults) after the edge sampling the start bit's cycle start, i.e. on the 74th sampling edge counting the start bit as 1.
REQ-017 rx values during ADDR/OP/DATA SHALL never abort a frame; no start-bit revalidation, no timeout.
REQ-018 Back-to-back: a start bit sampled on the edge immediately after the frame's last payload bit SHALL begin a new frame (no idle gap required).
REQ-019 Address compare SHALL be exact over all ADDR_W bits; no broadcast address.
REQ-020 Captured payload SHALL be held internally only; it has no output.
REQ-021 Changes to the address input mid-frame SHALL only matter at the final-bit edge.

Reset
REQ-022 nRst low SHALL asynchronously force state IDLE, counter 0, all shift registers 0, opcode 0.
REQ-023 Reset mid-frame SHALL discard the partial frame; after release, reception restarts only on a new start bit.
REQ-024 Reset release SHALL take effect synchronously; first sampling edge after release is treated as IDLE.

Structure
REQ-025 Shared package pctrl_pkg SHALL hold the FSM state typedef and the constants ADDR_W, OP_W, DATA_W and FRAME_LEN (=1+ADDR_W+OP_W+DATA_W).
REQ-026 One sub-module pctrl_shift (parameterised width, serial-in MSB-first shift register with enable and async reset) SHALL be instantiated for the address, opcode and payload fields.

Verification
REQ-027 address=0xAA, rx idle 1 for 500 cycles after reset -> opcode stays 0.
REQ-028 Frame addr 0xAA, op 4, data 100 -> opcode becomes 4 on the 74th sampling edge, not earlier, then holds.
REQ-029 Frame addr 0x55, op 6 after REQ-028 -> opcode stays 4.
REQ-030 Back-to-back frames (0xAA, op 2) then (0xAA, op 7) with no gap -> opcode 2 at edge 74, 7 at edge 148.
REQ-031 nRst pulsed low at bit 40 of a 0xAA/op 5 frame, remaining bits sent -> opcode 0 and no update; next full 0xAA/op 5 frame -> opcode 5.
REQ-032 Frame addr 0xAB (1-bit mismatch), op 3 -> opcode unchanged.
